// File: rtl/memory_spram_initiator.sv
// Purpose : valid/ready bus initiator for a synchronous single-port SPRAM, with post-reset
//           wake delay and an optional array clear sweep (enabled by the SPRAM_CLEAR_EN macro).
// Latency : a request is issued combinationally on the accept edge; its response is valid 1 cycle later.
// Backpr. : one response slot; req_ready drops while a response is held and rsp_ready is low.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_wen, req_wmask, req_addr, req_wdata : request side
//   rsp_valid/rsp_ready, rsp_rdata                                 : response side (0 for writes)
//   busy                                                           : wake or clear in progress
//   mem_wen, mem_wmask, mem_addr, mem_wdata, mem_rdata             : SPRAM port
module memory_spram_initiator #(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAKE_CYCLES = 4,
  parameter int CLEAR_WORDS = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [3:0]            req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  busy,
  output logic                  mem_wen,
  output logic [3:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_WAKE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WCW-1:0] wake_cnt;
  logic           wake_last;
  logic           accept;

  logic           rsp_first;  // response is in its first valid cycle: data comes straight from the SPRAM
  logic           rsp_rd;     // outstanding response belongs to a read
  logic [31:0]    rsp_hold;   // captured data while the consumer stalls

  assign wake_last = (wake_cnt == WCW'(WAKE_CYCLES - 1));

  // Wake counter: runs only in WAKE and restarts from 0 on every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wake_cnt <= '0;
    end else if (state == S_WAKE && !wake_last) begin
      wake_cnt <= wake_cnt + WCW'(1);
    end
  end

`ifdef SPRAM_CLEAR_EN
  // One extra bit so a full-array sweep (CLEAR_WORDS = 2^ADDR_WIDTH) ends without wrapping.
  logic [ADDR_WIDTH:0] sweep;
  logic                sweep_last;

  assign sweep_last = (sweep == (ADDR_WIDTH + 1)'(CLEAR_WORDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep <= '0;
    end else if (state == S_CLEAR) begin
      sweep <= sweep + (ADDR_WIDTH + 1)'(1);
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_WAKE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAKE: begin
        if (wake_last) begin
`ifdef SPRAM_CLEAR_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = S_RUN;
`endif
        end
      end
`ifdef SPRAM_CLEAR_EN
      S_CLEAR: begin
        if (sweep_last) state_nxt = S_RUN;
      end
`endif
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_WAKE;
    endcase
  end

  // Output logic. Memory port is idle (all zero) in WAKE, so reset pulls mem_wen low asynchronously.
  always_comb begin
    busy      = 1'b1;
    req_ready = 1'b0;
    accept    = 1'b0;
    mem_wen   = 1'b0;
    mem_wmask = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    case (state)
`ifdef SPRAM_CLEAR_EN
      S_CLEAR: begin
        mem_wen   = 1'b1;
        mem_wmask = 4'hF;
        mem_addr  = sweep[ADDR_WIDTH-1:0];
      end
`endif
      S_RUN: begin
        busy      = 1'b0;
        req_ready = !rsp_valid || rsp_ready;
        accept    = req_valid && req_ready;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_wen   = accept && req_wen;
        mem_wmask = (accept && req_wen) ? req_wmask : 4'h0;
      end
      default: ;
    endcase
  end

  // Response slot. SPRAM read data is only valid in the cycle right after the access,
  // so a stalled response must be captured at the end of its first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_first <= 1'b0;
      rsp_rd    <= 1'b0;
      rsp_hold  <= 32'd0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_first <= 1'b1;
        rsp_rd    <= !req_wen;
      end else begin
        rsp_first <= 1'b0;
        if (rsp_ready) rsp_valid <= 1'b0;
      end

      if (rsp_valid && !rsp_ready && rsp_first) begin
        rsp_hold <= rsp_rdata;
      end else if (rsp_valid && rsp_ready) begin
        rsp_hold <= 32'd0;
      end
    end
  end

  assign rsp_rdata = rsp_first ? (rsp_rd ? mem_rdata : 32'd0) : rsp_hold;

endmodule

// File: tb/tb_memory_spram_initiator.sv
// Purpose : directed bench for memory_spram_initiator with a behavioural SPRAM model.
// Latency : stimulus driven on falling edges, outputs sampled on falling edges.
// Backpr. : exercises rsp_ready stalls, back-to-back traffic and reset during a stall.
module tb_memory_spram_initiator;

  localparam int AW   = 14;
  localparam int WAKE = 4;
  localparam int CLRW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wen = 1'b0;
  logic [3:0]    req_wmask = 4'h0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          busy;
  logic          mem_wen;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  memory_spram_initiator #(
    .ADDR_WIDTH (AW),
    .WAKE_CYCLES(WAKE),
    .CLEAR_WORDS(CLRW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen  (req_wen),
    .req_wmask(req_wmask),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .mem_wen  (mem_wen),
    .mem_wmask(mem_wmask),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SPRAM: byte-masked write, registered read.
  logic [31:0] mem [0:63];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_A5A5;
    mem_rdata = 32'd0;
  end
  always @(posedge clk) begin
    if (mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else begin
      mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the falling edge where rst is released: checks WAKE (and CLEAR) and ends at the first RUN cycle.
  task automatic wake_seq;
    for (int k = 1; k <= WAKE; k++) begin
      check("wake_rdy", {31'd0, req_ready}, 32'd0);
      check("wake_busy", {31'd0, busy}, 32'd1);
      check("wake_wen", {31'd0, mem_wen}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
`ifdef SPRAM_CLEAR_EN
    for (int k = 0; k < CLRW; k++) begin
      check("clr_wen", {31'd0, mem_wen}, 32'd1);
      check("clr_addr", {18'd0, mem_addr}, k);
      check("clr_data", mem_wdata, 32'd0);
      check("clr_mask", {28'd0, mem_wmask}, 32'hF);
      check("clr_rdy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
`endif
    check("run_rdy", {31'd0, req_ready}, 32'd1);
    check("run_busy", {31'd0, busy}, 32'd0);
  endtask

  // Single transfer with rsp_ready high, entered and left on a falling edge.
  task automatic xfer(input logic wen, input logic [3:0] mask, input logic [AW-1:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp);
    req_valid = 1'b1; req_wen = wen; req_wmask = mask; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b1;
    #1;
    check("x_rdy", {31'd0, req_ready}, 32'd1);
    check("x_wen", {31'd0, mem_wen}, {31'd0, wen});
    check("x_mask", {28'd0, mem_wmask}, wen ? {28'd0, mask} : 32'd0);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_wen = 1'b0;
    check("x_rsp_vld", {31'd0, rsp_valid}, 32'd1);
    check("x_rsp_dat", rsp_rdata, exp);
    @(posedge clk); @(negedge clk);
    check("x_rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  logic [AW-1:0] b2b_addr [3];
  logic [31:0]   b2b_exp  [3];

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_rdy", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_vld", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", rsp_rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_mask", {28'd0, mem_wmask}, 32'd0);
    check("rst_addr", {18'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    wake_seq();

`ifdef SPRAM_CLEAR_EN
    xfer(1'b0, 4'h0, 14'h000F, 32'd0, 32'd0);
`endif

    // Write/read and partial writes
    xfer(1'b1, 4'hF, 14'h0010, 32'hDEAD_BEEF, 32'd0);
    xfer(1'b0, 4'h0, 14'h0010, 32'd0, 32'hDEAD_BEEF);
    xfer(1'b1, 4'hF, 14'h0020, 32'h1122_3344, 32'd0);
    xfer(1'b1, 4'b0100, 14'h0020, 32'hAABB_CCDD, 32'd0);
    xfer(1'b0, 4'h0, 14'h0020, 32'd0, 32'h11BB_3344);
    xfer(1'b1, 4'h0, 14'h0020, 32'hFFFF_FFFF, 32'd0);
    xfer(1'b0, 4'h0, 14'h0020, 32'd0, 32'h11BB_3344);

    // Stalled response: data must hold while the SPRAM output moves on
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 14'h0010; rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = 14'h0020;
    for (int k = 0; k < 5; k++) begin
      check("stall_vld", {31'd0, rsp_valid}, 32'd1);
      check("stall_dat", rsp_rdata, 32'hDEAD_BEEF);
      check("stall_rdy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_rel_rdy", {31'd0, req_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("stall_done", {31'd0, rsp_valid}, 32'd0);

    // Back-to-back reads at full rate
    b2b_addr[0] = 14'h0010; b2b_exp[0] = 32'hDEAD_BEEF;
    b2b_addr[1] = 14'h0020; b2b_exp[1] = 32'h11BB_3344;
    b2b_addr[2] = 14'h0010; b2b_exp[2] = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_wen = 1'b0; req_addr = b2b_addr[k];
      #1;
      check("b2b_rdy", {31'd0, req_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      check("b2b_vld", {31'd0, rsp_valid}, 32'd1);
      check("b2b_dat", rsp_rdata, b2b_exp[k]);
    end
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("b2b_done", {31'd0, rsp_valid}, 32'd0);

    // Reset while a response is stalled
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 14'h0010; rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("mid_vld_pre", {31'd0, rsp_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_vld", {31'd0, rsp_valid}, 32'd0);
    check("mid_dat", rsp_rdata, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_rdy", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    wake_seq();
    xfer(1'b0, 4'h0, 14'h0010, 32'd0, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
